// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
// MEM-stage data-memory access sequencer. Takes the load/store held in EX/MEM,
// runs a variable-latency req/ready handshake with data memory, stalls the
// upstream pipeline and bubbles MEM/WB until the access completes, then
// presents lane-aligned, sign/zero-extended load data to MEM/WB.
//
// State table:
//   IDLE | waiting for a load/store; faults are flagged here without a request
//   BUSY | request outstanding, waiting for mem_ready or the timeout
//   DONE | one cycle: pipeline advances, MEM/WB captures the result
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   MemRead_in, MemWrite_in  EX/MEM load / store request
//   funct3_in                RV32I access size and sign
//   addr_in, wdata_in        byte address, store data (low bits)
//   mem_req, mem_we          memory request and write select
//   mem_addr                 word-aligned address
//   mem_wdata, mem_wstrb     lane-replicated store data and byte enables
//   mem_ready, mem_rdata     memory completion and read word
//   stall, wb_bubble         pipeline freeze and MEM/WB writeback kill
//   load_data_out            extended load result
//   fault_out, timeout_out   one-cycle fault / timeout pulses
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        wb_bubble,
    output logic [31:0] load_data_out,
    output logic        fault_out,
    output logic        timeout_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter value in the last allowed BUSY cycle without mem_ready.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        timed_out;
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;
    logic        is_store_q;
    logic [31:0] load_q;

    logic        op_any;
    logic        op_fault;
    logic [3:0]  lane_wstrb;
    logic [31:0] lane_wdata;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;

    // Request qualification: size/sign legality, alignment, read+write conflict.
    always_comb begin
        op_any   = MemRead_in | MemWrite_in;
        op_fault = 1'b0;
        case (funct3_in)
            3'b000:  op_fault = 1'b0;
            3'b001:  op_fault = addr_in[0];
            3'b010:  op_fault = |addr_in[1:0];
            3'b100:  op_fault = MemWrite_in;
            3'b101:  op_fault = MemWrite_in | addr_in[0];
            default: op_fault = 1'b1;
        endcase
        if (MemRead_in && MemWrite_in) begin
            op_fault = 1'b1;
        end
        if (!op_any) begin
            op_fault = 1'b0;
        end
    end

    // Store lane steering; replicated data lets memory pick any enabled lane.
    always_comb begin
        lane_wstrb = 4'b0000;
        lane_wdata = 32'h0;
        if (MemWrite_in) begin
            case (funct3_in[1:0])
                2'b00: begin
                    lane_wstrb = 4'b0001 << addr_in[1:0];
                    lane_wdata = {4{wdata_in[7:0]}};
                end
                2'b01: begin
                    lane_wstrb = 4'b0011 << addr_in[1:0];
                    lane_wdata = {2{wdata_in[15:0]}};
                end
                default: begin
                    lane_wstrb = 4'b1111;
                    lane_wdata = wdata_in;
                end
            endcase
        end
    end

    // Load extraction from the returned word using the latched byte offset.
    always_comb begin
        sel_byte = mem_rdata[{off_q, 3'b000} +: 8];
        sel_half = mem_rdata[{off_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  load_ext = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_ext = {24'h0, sel_byte};
            3'b001:  load_ext = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_ext = {16'h0, sel_half};
            default: load_ext = mem_rdata;
        endcase
        if (is_store_q) begin
            load_ext = 32'h0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= 8'h0;
            timed_out  <= 1'b0;
            off_q      <= 2'b00;
            funct3_q   <= 3'b000;
            is_store_q <= 1'b0;
            load_q     <= 32'h0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_wstrb  <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (op_any && !op_fault) begin
                        state      <= BUSY;
                        wait_cnt   <= 8'h0;
                        timed_out  <= 1'b0;
                        off_q      <= addr_in[1:0];
                        funct3_q   <= funct3_in;
                        is_store_q <= MemWrite_in;
                        mem_we     <= MemWrite_in;
                        mem_addr   <= {addr_in[31:2], 2'b00};
                        mem_wdata  <= lane_wdata;
                        mem_wstrb  <= lane_wstrb;
                    end
                end
                BUSY: begin
                    if (mem_ready || wait_cnt == WAIT_LAST) begin
                        // mem_ready wins over a timeout landing in the same cycle.
                        state     <= DONE;
                        timed_out <= !mem_ready;
                        load_q    <= mem_ready ? load_ext : 32'h0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 32'h0;
                        mem_wdata <= 32'h0;
                        mem_wstrb <= 4'b0000;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    timed_out <= 1'b0;
                    wait_cnt  <= 8'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_req       = (state == BUSY);
    assign load_data_out = load_q;

    // IDLE decode is combinational so a new op stalls in its first cycle;
    // gated by rst so every output reads 0 during reset.
    always_comb begin
        stall       = 1'b0;
        wb_bubble   = 1'b0;
        fault_out   = 1'b0;
        timeout_out = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    fault_out = op_fault;
                    stall     = op_any & ~op_fault;
                    wb_bubble = op_any;
                end
                BUSY: begin
                    stall     = 1'b1;
                    wb_bubble = 1'b1;
                end
                DONE: begin
                    wb_bubble   = timed_out;
                    timeout_out = timed_out;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_ctrl
// Directed scenarios plus randomized loads/stores against a behavioural
// reference model of the access rules (legality, lanes, extension, latency).
// -----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead_in, MemWrite_in;
    logic [2:0]  funct3_in;
    logic [31:0] addr_in, wdata_in;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall, wb_bubble;
    logic [31:0] load_data_out;
    logic        fault_out, timeout_out;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .funct3_in(funct3_in), .addr_in(addr_in), .wdata_in(wdata_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .stall(stall), .wb_bubble(wb_bubble), .load_data_out(load_data_out),
        .fault_out(fault_out), .timeout_out(timeout_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_fault(input bit rd, input bit wr, input logic [2:0] f3,
                                       input logic [31:0] a);
        int sz;
        if (!rd && !wr) return 1'b0;
        if (rd && wr) return 1'b1;
        if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        sz = 1 << f3[1:0];
        return (a % sz) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rdat);
        int     sz, o;
        longint m, v;
        sz = 1 << f3[1:0];
        o  = int'(a % 4);
        m  = longint'(1) << (8 * sz);
        v  = longint'(rdat >> (8 * o)) % m;
        if (!f3[2] && sz < 4 && v >= m / 2) v = v - m;
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = 1 << f3[1:0];
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int sz;
        logic [31:0] r;
        sz = 1 << f3[1:0];
        r  = 32'h0;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = wd[8*(b % sz) +: 8];
        return r;
    endfunction

    // Entry and exit: #1 after a rising edge with the DUT in IDLE.
    task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int waits, input logic [31:0] rdat);
        bit flt, tmo;
        int exp_busy, busy_n, stall_n;
        logic [31:0] exp_ld;
        flt = model_fault(rd, wr, f3, a);
        MemRead_in = rd; MemWrite_in = wr; funct3_in = f3; addr_in = a; wdata_in = wd;
        mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("idle_fault", 32'(fault_out), 32'(flt));
        chk("idle_stall", 32'(stall), 32'((rd | wr) & ~flt));
        chk("idle_bubble", 32'(wb_bubble), 32'(rd | wr));
        chk("idle_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        MemRead_in = 1'b0; MemWrite_in = 1'b0;
        funct3_in = 3'($urandom); addr_in = $urandom; wdata_in = $urandom;
        if (flt || !(rd || wr)) begin
            mem_ready = 1'b0;
            @(negedge clk);
            chk("no_start_req", 32'(mem_req), 32'd0);
            chk("no_start_stall", 32'(stall), 32'd0);
            @(posedge clk); #1;
            return;
        end
        tmo      = (waits >= T);
        exp_busy = tmo ? T : waits + 1;
        busy_n   = 0;
        stall_n  = 1;
        for (int k = 0; k < T + 3; k++) begin
            mem_ready = (k == waits);
            mem_rdata = (k == waits) ? rdat : $urandom;
            @(negedge clk);
            if (mem_req !== 1'b1) break;
            busy_n++;
            if (stall === 1'b1) stall_n++;
            chk("busy_bubble", 32'(wb_bubble), 32'd1);
            chk("busy_we", 32'(mem_we), 32'(wr));
            chk("busy_addr", mem_addr, {a[31:2], 2'b00});
            chk("busy_wstrb", 32'(mem_wstrb), wr ? 32'(model_wstrb(f3, a)) : 32'd0);
            if (wr) chk("busy_wdata", mem_wdata, model_wdata(f3, wd));
            @(posedge clk); #1;
        end
        exp_ld = (tmo || wr) ? 32'h0 : model_load(f3, a, rdat);
        chk("busy_cycles", 32'(busy_n), 32'(exp_busy));
        chk("stall_cycles", 32'(stall_n), 32'(exp_busy + 1));
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_bubble", 32'(wb_bubble), 32'(tmo));
        chk("done_timeout", 32'(timeout_out), 32'(tmo));
        chk("done_fault", 32'(fault_out), 32'd0);
        chk("done_load", load_data_out, exp_ld);
        @(posedge clk); #1;
        mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("after_req", 32'(mem_req), 32'd0);
        chk("after_timeout", 32'(timeout_out), 32'd0);
        chk("after_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
    endtask

    task automatic reset_mid_busy();
        MemRead_in = 1'b1; MemWrite_in = 1'b0; funct3_in = 3'b010; addr_in = 32'h100;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        MemRead_in = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_pre_req", 32'(mem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_bubble", 32'(wb_bubble), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_load", load_data_out, 32'h0);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("rst_hold_req", 32'(mem_req), 32'd0);
        chk("rst_hold_timeout", 32'(timeout_out), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        mem_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        MemRead_in = 1'b0; MemWrite_in = 1'b0; funct3_in = 3'b000;
        addr_in = 32'h0; wdata_in = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        MemRead_in = 1'b1; funct3_in = 3'b010; addr_in = 32'h100;
        #1;
        chk("reset_req", 32'(mem_req), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_bubble", 32'(wb_bubble), 32'd0);
        chk("reset_load", load_data_out, 32'h0);
        MemRead_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        do_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF0000);
        do_op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF0000);
        do_op(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 2, 32'hBEEF0000);
        do_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h00001234, 3, 32'h0);
        do_op(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h0);
        do_op(1'b0, 1'b1, 3'b100, 32'h300, 32'h55, 0, 32'h0);
        do_op(1'b1, 1'b1, 3'b010, 32'h300, 32'h55, 0, 32'h0);
        do_op(1'b0, 1'b0, 3'b010, 32'h300, 32'h55, 0, 32'h0);
        do_op(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 9, 32'h12345678);
        do_op(1'b0, 1'b1, 3'b000, 32'h401, 32'hA5, T - 1, 32'h0);
        reset_mid_busy();
        do_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hCAFEF00D);

        for (int i = 0; i < 300; i++) begin
            int kind;
            bit rd, wr;
            kind = int'($urandom_range(0, 9));
            rd   = (kind <= 5);
            wr   = (kind == 0) || (kind >= 6);
            do_op(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom,
                  int'($urandom_range(0, T + 1)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
